// File: rtl/program_sequencer.sv
// Program counter with signed relative branch, stall and a flop-based call/return stack.
// Optional sticky stack error flag is built only when PC_STACK_ERR_EN is defined.
module program_sequencer #(
  parameter int unsigned P_SIZE      = 6,
  parameter int unsigned STACK_DEPTH = 4,
  parameter logic [P_SIZE-1:0] RESET_VEC = '0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   stall,
  input  logic                                   inc,
  input  logic                                   branchAbs,
  input  logic                                   branchRel,
  input  logic                                   call,
  input  logic                                   ret,
  input  logic [P_SIZE-1:0]                      branchAddress,
  output logic [P_SIZE-1:0]                      addressOut,
  output logic [$clog2(STACK_DEPTH+1)-1:0]       stackDepth,
  output logic                                   stackFull,
  output logic                                   stackEmpty,
  output logic                                   stackErr
);

  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

  logic [P_SIZE-1:0] pc_q, pc_nxt;
  logic [DW-1:0]     depth_q, depth_nxt;
  logic [P_SIZE-1:0] stack_mem [STACK_DEPTH];
  logic [P_SIZE-1:0] stack_top;
  logic [P_SIZE-1:0] pc_plus1;
  logic              push;
  logic              full;
  logic              empty;

  assign full     = (depth_q == DW'(STACK_DEPTH));
  assign empty    = (depth_q == DW'(0));
  assign pc_plus1 = pc_q + P_SIZE'(1);

  // Top-of-stack read mux: entry depth-1, decoded without a variable-width index
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) begin
        stack_top = stack_mem[i];
      end
    end
  end

  // Next PC / depth, strict priority: stall > ret > call > branchAbs > branchRel > inc
  always_comb begin
    pc_nxt    = pc_q;
    depth_nxt = depth_q;
    push      = 1'b0;
    if (stall) begin
      pc_nxt    = pc_q;
    end else if (ret) begin
      if (!empty) begin
        pc_nxt    = stack_top;
        depth_nxt = depth_q - DW'(1);
      end else begin
        pc_nxt    = pc_plus1;
      end
    end else if (call) begin
      pc_nxt = branchAddress;
      if (!full) begin
        push      = 1'b1;
        depth_nxt = depth_q + DW'(1);
      end
    end else if (branchAbs) begin
      pc_nxt = branchAddress;
    end else if (branchRel) begin
      pc_nxt = pc_q + branchAddress;
    end else if (inc) begin
      pc_nxt = pc_plus1;
    end
  end

  // PC and depth registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VEC;
      depth_q <= '0;
    end else begin
      pc_q    <= pc_nxt;
      depth_q <= depth_nxt;
    end
  end

  // Stack storage needs no reset: entries above depth are never read
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push && !rst && depth_q == DW'(i)) begin
        stack_mem[i] <= pc_plus1;
      end
    end
  end

  assign addressOut = pc_q;
  assign stackDepth = depth_q;
  assign stackFull  = full;
  assign stackEmpty = empty;

`ifdef PC_STACK_ERR_EN
  logic err_q;
  logic err_evt;

  // Overflow: call (not pre-empted by ret) into a full stack; underflow: ret on empty
  assign err_evt = !stall && ((ret && empty) || (!ret && call && full));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_evt) begin
      err_q <= 1'b1;
    end
  end

  assign stackErr = err_q;
`else
  assign stackErr = 1'b0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Directed and randomized bench for program_sequencer against a queue-based reference model.
module tb_program_sequencer;

`ifdef PC_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, stall, inc, branchAbs, branchRel, call, ret;
  logic [5:0] branchAddress;
  logic [5:0] addressOut, addressOut10;
  logic [2:0] stackDepth, stackDepth10;
  logic       stackFull, stackEmpty, stackErr;
  logic       stackFull10, stackEmpty10, stackErr10;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_pc;
  int m_q[$];
  bit m_err;

  always #5 clk = ~clk;

  program_sequencer #(.P_SIZE(6), .STACK_DEPTH(4), .RESET_VEC(6'd0)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .inc(inc), .branchAbs(branchAbs),
    .branchRel(branchRel), .call(call), .ret(ret), .branchAddress(branchAddress),
    .addressOut(addressOut), .stackDepth(stackDepth), .stackFull(stackFull),
    .stackEmpty(stackEmpty), .stackErr(stackErr)
  );

  program_sequencer #(.P_SIZE(6), .STACK_DEPTH(4), .RESET_VEC(6'd10)) u_dut10 (
    .clk(clk), .rst(rst), .stall(stall), .inc(inc), .branchAbs(branchAbs),
    .branchRel(branchRel), .call(call), .ret(ret), .branchAddress(branchAddress),
    .addressOut(addressOut10), .stackDepth(stackDepth10), .stackFull(stackFull10),
    .stackEmpty(stackEmpty10), .stackErr(stackErr10)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input bit r, s, i, ba, br, c, rt, input int a);
    if (r) begin
      m_pc = 0; m_q.delete(); m_err = 1'b0;
    end else if (s) begin
      // frozen
    end else if (rt) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin m_pc = (m_pc + 1) % 64; m_err = 1'b1; end
    end else if (c) begin
      if (m_q.size() < 4) m_q.push_back((m_pc + 1) % 64);
      else m_err = 1'b1;
      m_pc = a;
    end else if (ba) m_pc = a;
    else if (br) m_pc = (m_pc + a) % 64;
    else if (i) m_pc = (m_pc + 1) % 64;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".pc"},    32'(addressOut), 32'(m_pc));
    chk({tag, ".depth"}, 32'(stackDepth), 32'(m_q.size()));
    chk({tag, ".full"},  32'(stackFull),  32'(m_q.size() == 4));
    chk({tag, ".empty"}, 32'(stackEmpty), 32'(m_q.size() == 0));
    chk({tag, ".err"},   32'(stackErr),   32'(ERR_EN & m_err));
  endtask

  // One clock: drive at negedge, model on posedge, sample 1 time unit later
  task automatic cyc(input string tag, input bit r, s, i, ba, br, c, rt, input logic [5:0] a);
    @(negedge clk);
    rst = r; stall = s; inc = i; branchAbs = ba; branchRel = br;
    call = c; ret = rt; branchAddress = a;
    @(posedge clk);
    model_step(r, s, i, ba, br, c, rt, int'(a));
    #1;
    check_model(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 6'd0);
  endtask

  task automatic reset(input string tag);
    cyc(tag, 1, 0, 0, 0, 0, 0, 0, 6'd0);
  endtask

  initial begin
    logic [5:0] held;
    rst = 1'b0; stall = 1'b0; inc = 1'b0; branchAbs = 1'b0; branchRel = 1'b0;
    call = 1'b0; ret = 1'b0; branchAddress = '0;
    m_pc = 0; m_err = 1'b0;

    // Reset and quiet cycles
    reset("rst");
    for (int k = 0; k < 3; k++) idle("rst_idle");
    chk("rst.pc0", 32'(addressOut), 32'd0);
    chk("rst.vec10", 32'(addressOut10), 32'd10);
    chk("rst.depth10", 32'(stackDepth10), 32'd0);

    // Full increment run with wrap, then a stall
    reset("inc_rst");
    for (int k = 0; k < 64; k++) cyc("inc", 0, 0, 1, 0, 0, 0, 0, 6'd0);
    chk("inc.wrap", 32'(addressOut), 32'd0);
    for (int k = 0; k < 7; k++) cyc("inc", 0, 0, 1, 0, 0, 0, 0, 6'd0);
    held = addressOut;
    cyc("stall", 0, 1, 1, 1, 0, 1, 0, 6'd33);
    chk("stall.hold", 32'(addressOut), 32'(held));

    // Branches
    reset("br_rst");
    cyc("babs", 0, 0, 0, 1, 0, 0, 0, 6'd5);
    chk("babs.5", 32'(addressOut), 32'd5);
    cyc("brel", 0, 0, 0, 0, 1, 0, 0, 6'd8);
    chk("brel.13", 32'(addressOut), 32'd13);
    cyc("brel_neg", 0, 0, 0, 0, 1, 0, 0, 6'h3E);
    chk("brel.11", 32'(addressOut), 32'd11);
    cyc("babs_inc", 0, 0, 1, 1, 0, 0, 0, 6'd20);
    chk("babs_inc.20", 32'(addressOut), 32'd20);

    // Nested call / return
    reset("call_rst");
    cyc("to3", 0, 0, 0, 1, 0, 0, 0, 6'd3);
    cyc("call40", 0, 0, 0, 0, 0, 1, 0, 6'd40);
    chk("call40.pc", 32'(addressOut), 32'd40);
    cyc("call50", 0, 0, 0, 0, 0, 1, 0, 6'd50);
    chk("call50.depth", 32'(stackDepth), 32'd2);
    cyc("ret1", 0, 0, 0, 0, 0, 0, 1, 6'd0);
    chk("ret1.pc41", 32'(addressOut), 32'd41);
    cyc("ret2", 0, 0, 0, 0, 0, 0, 1, 6'd0);
    chk("ret2.pc4", 32'(addressOut), 32'd4);

    // Overflow then underflow
    reset("ovf_rst");
    for (int k = 1; k <= 5; k++) cyc("ovf_call", 0, 0, 0, 0, 0, 1, 0, 6'(k));
    chk("ovf.pc5", 32'(addressOut), 32'd5);
    chk("ovf.full", 32'(stackFull), 32'd1);
    chk("ovf.err", 32'(stackErr), 32'(ERR_EN));
    for (int k = 0; k < 4; k++) cyc("pop", 0, 0, 0, 0, 0, 0, 1, 6'd0);
    chk("pop.pc1", 32'(addressOut), 32'd1);
    cyc("unf", 0, 0, 0, 0, 0, 0, 1, 6'd0);
    chk("unf.pc2", 32'(addressOut), 32'd2);
    chk("unf.err", 32'(stackErr), 32'(ERR_EN));

    // Reset during call; call+ret collision
    reset("mix_rst");
    cyc("c10", 0, 0, 0, 0, 0, 1, 0, 6'd10);
    cyc("c20", 0, 0, 0, 0, 0, 1, 0, 6'd20);
    cyc("rst_call", 1, 0, 0, 0, 0, 1, 0, 6'd30);
    chk("rst_call.pc", 32'(addressOut), 32'd0);
    chk("rst_call.depth", 32'(stackDepth), 32'd0);
    cyc("c30", 0, 0, 0, 0, 0, 1, 0, 6'd30);
    cyc("call_ret", 0, 0, 0, 0, 0, 1, 1, 6'd55);
    chk("call_ret.pc1", 32'(addressOut), 32'd1);
    chk("call_ret.depth", 32'(stackDepth), 32'd0);

    // Randomized traffic against the model
    reset("rnd_rst");
    for (int k = 0; k < 400; k++) begin
      cyc("rnd",
          $urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, 6'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
